// File: rtl/mult_sequencer.sv
// Sequences one signed multiply at a time through an external multiplier:
// accept operands, pulse start, wait for completion or timeout, hold the result.
module mult_sequencer #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned START_CYCLES = 2,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic [WIDTH-1:0]   mul_a,
   output logic [WIDTH-1:0]   mul_b,
   output logic               mul_start,
   input  logic               mul_busy,
   input  logic [2*WIDTH-1:0] mul_ab,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_ab,
   output logic               out_err,
   output logic [7:0]         done_count
);

   localparam logic [3:0] ScntLast = 4'(START_CYCLES - 1);
   localparam logic [7:0] TcntLast = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StStart, StWait, StCapture} state_e;

   state_e     state_q, state_d;
   logic [3:0] scnt_q;
   logic [7:0] tcnt_q;
   logic       first_q;
   logic       tflag_q;
   logic       accept;
   logic       timeout_hit;

   assign in_ready = (state_q == StIdle) && !out_valid && !rst;

   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      timeout_hit = 1'b0;
      mul_start   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid && in_ready) begin
               state_d = StStart;
               accept  = 1'b1;
            end
         end
         StStart: begin
            mul_start = 1'b1;
            if (scnt_q == ScntLast) state_d = StWait;
         end
         StWait: begin
            // busy is not trusted in the first WAIT cycle; timeout applies only here
            if (!first_q && !mul_busy) begin
               state_d = StCapture;
            end else if (tcnt_q >= TcntLast) begin
               state_d     = StCapture;
               timeout_hit = 1'b1;
            end
         end
         StCapture: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         scnt_q     <= '0;
         tcnt_q     <= '0;
         first_q    <= 1'b0;
         tflag_q    <= 1'b0;
         mul_a      <= '0;
         mul_b      <= '0;
         out_valid  <= 1'b0;
         out_ab     <= '0;
         out_err    <= 1'b0;
         done_count <= '0;
      end else begin
         state_q <= state_d;
         first_q <= (state_q == StStart) && (state_d == StWait);
         if (accept) begin
            mul_a   <= in_a;
            mul_b   <= in_b;
            scnt_q  <= '0;
            tcnt_q  <= '0;
            tflag_q <= 1'b0;
         end else begin
            if (state_q == StStart) scnt_q <= scnt_q + 4'd1;
            if (state_q == StStart || state_q == StWait) tcnt_q <= tcnt_q + 8'd1;
            if (timeout_hit) tflag_q <= 1'b1;
         end
         if (state_q == StCapture) begin
            out_ab    <= mul_ab;
            out_err   <= tflag_q;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
            done_count <= done_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural 9-cycle-busy multiplier.
module tb_mult_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a, in_b;
   logic [7:0]  mul_a, mul_b;
   logic        mul_start;
   logic        mul_busy;
   logic [15:0] mul_ab;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_ab;
   logic        out_err;
   logic [7:0]  done_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mult_sequencer #(.WIDTH(8), .START_CYCLES(2), .TIMEOUT(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_start  (mul_start),
      .mul_busy   (mul_busy),
      .mul_ab     (mul_ab),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ab     (out_ab),
      .out_err    (out_err),
      .done_count (done_count)
   );

   // Model multiplier: product latched on the rising start, busy for 9 cycles.
   logic [3:0]  busy_cnt = '0;
   logic        start_d  = 1'b0;
   logic        stuck    = 1'b0;
   logic [15:0] prod     = '0;

   always @(posedge clk) begin
      start_d <= mul_start;
      if (mul_start && !start_d) begin
         busy_cnt <= 4'd9;
         prod     <= $signed({{8{mul_a[7]}}, mul_a}) * $signed({{8{mul_b[7]}}, mul_b});
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 4'd1;
      end
   end

   assign mul_busy = stuck || (busy_cnt != 0);
   assign mul_ab   = prod;

   int start_total = 0;
   int valid_total = 0;
   always @(posedge clk) begin
      if (mul_start) start_total <= start_total + 1;
      if (out_valid) valid_total <= valid_total + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
   endtask

   // Returns just after the accepting edge.
   task automatic send(input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      while (!in_ready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 300) check("send_timeout", 32'(n), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output logic [15:0] ab, output logic err, output int n,
                              output int rdy_hits);
      n = 0;
      rdy_hits = 0;
      while (!out_valid && n < 300) begin
         if (in_ready) rdy_hits++;
         @(posedge clk); #1;
         n++;
      end
      if (n >= 300) check("result_timeout", 32'(n), 32'd0);
      ab  = out_ab;
      err = out_err;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] ab, ab0;
      logic        err;
      int          n, hits, s0, v0, bad;

      rst = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      out_ready = 1'b1;

      // Reset state
      @(posedge clk); #1;
      check("rst_in_ready_low", in_ready, 0);
      @(posedge clk); #1;
      check("rst_mul_start", mul_start, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_ab", out_ab, 0);
      check("rst_done", done_count, 0);
      rst = 1'b0;
      #1;
      check("rst_in_ready_after", in_ready, 1);

      // 3 x 17
      s0 = start_total;
      send(8'd3, 8'd17);
      wait_result(ab, err, n, hits);
      check("t1_ab", ab, 16'h0033);
      check("t1_err", err, 0);
      check("t1_start_cycles", 32'(start_total - s0), 2);
      check("t1_in_ready_busy", 32'(hits), 0);
      @(posedge clk); #1;
      check("t1_valid_drop", out_valid, 0);
      check("t1_done", done_count, 1);

      // Back-to-back 7x7 then -3x5
      do_reset();
      send(8'd7, 8'd7);
      wait_result(ab, err, n, hits);
      check("t2a_ab", ab, 16'h0031);
      check("t2a_in_ready_busy", 32'(hits), 0);
      send(8'hFD, 8'd5);
      wait_result(ab, err, n, hits);
      check("t2b_ab", ab, 16'hFFF1);
      check("t2b_in_ready_busy", 32'(hits), 0);
      @(posedge clk); #1;
      check("t2_done", done_count, 2);

      // Back-pressure: result held, new request blocked
      do_reset();
      out_ready = 1'b0;
      send(8'd6, 8'd9);
      wait_result(ab0, err, n, hits);
      check("t3_ab", ab0, 16'h0036);
      in_a = 8'd2;
      in_b = 8'd2;
      in_valid = 1'b1;
      s0 = start_total;
      bad = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (!out_valid || out_ab !== ab0 || in_ready) bad++;
      end
      check("t3_hold_stable", 32'(bad), 0);
      check("t3_no_accept", 32'(start_total - s0), 0);
      check("t3_done_held", done_count, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("t3_valid_drop", out_valid, 0);
      check("t3_done", done_count, 1);
      check("t3_ready_after", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_result(ab, err, n, hits);
      check("t3_second_ab", ab, 16'h0004);

      // Timeout with busy stuck high: 10 x -2
      do_reset();
      stuck = 1'b1;
      send(8'd10, 8'hFE);
      wait_result(ab, err, n, hits);
      check("t4_latency", 32'(n), 65);
      check("t4_err", err, 1);
      check("t4_ab", ab, 16'hFFEC);
      stuck = 1'b0;
      send(8'd4, 8'd5);
      wait_result(ab, err, n, hits);
      check("t4_next_err", err, 0);
      check("t4_next_ab", ab, 16'h0014);

      // Reset during WAIT
      do_reset();
      send(8'd3, 8'd3);
      repeat (4) begin
         @(posedge clk); #1;
      end
      v0 = valid_total;
      rst = 1'b1;
      #1;
      check("t5_in_ready_in_rst", in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("t5_mul_start", mul_start, 0);
      check("t5_in_ready", in_ready, 1);
      check("t5_mul_a", mul_a, 0);
      check("t5_done", done_count, 0);
      repeat (20) begin
         @(posedge clk); #1;
      end
      check("t5_no_result", 32'(valid_total - v0), 0);

      // done_count wrap after 256 results
      do_reset();
      for (int i = 0; i < 256; i++) begin
         send(8'(i), 8'd1);
         wait_result(ab, err, n, hits);
         @(posedge clk); #1;
         if (i == 254) check("t6_done_255", done_count, 255);
      end
      check("t6_last_ab", ab, 16'hFFFF);
      check("t6_wrap", done_count, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
